// File: rtl/sort_seq_ctrl_if.sv
// Handshake bundle for the batch sorter: valid/ready word input, valid/ready sorted output, status.
// The design side uses the slave modport; the source/sink side uses master.
interface sort_seq_ctrl_if #(
  parameter int N = 6,
  parameter int W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [W-1:0]               in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [W-1:0]               out_data;
  logic                       out_last;
  logic                       busy;
  logic [$clog2(N+1)-1:0]     sort_phases;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, sort_phases
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, sort_phases
  );
endinterface

// File: rtl/sort_seq_ctrl.sv
// Loads N words, runs one odd-even transposition phase per cycle (optionally stopping early),
// then drains ascending; out_valid rises k cycles after the last accept, output held under backpressure.
module sort_seq_ctrl #(
  parameter int N          = 6,
  parameter int W          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  sort_seq_ctrl_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SORT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [PW-1:0]   phases_q, phases_d;
  logic            noswap_q, noswap_d;
  logic [W-1:0]    buf_q [N];
  logic [W-1:0]    buf_d [N];
  logic [W-1:0]    cx    [N];
  logic            any_swap;
  logic            sort_done;
  logic            in_fire;
  logic            out_fire;
  logic            idx_at_end;

  assign in_fire    = (state_q == S_LOAD)  && bus.in_valid;
  assign out_fire   = (state_q == S_DRAIN) && bus.out_ready;
  assign idx_at_end = (idx_q == IW'(N - 1));

  // Pairs never overlap within a phase, so every exchange reads the pre-phase buffer.
  always_comb begin
    cx       = buf_q;
    any_swap = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if ((i[0] == phase_q[0]) && (buf_q[i] > buf_q[i+1])) begin
        cx[i]    = buf_q[i+1];
        cx[i+1]  = buf_q[i];
        any_swap = 1'b1;
      end
    end
  end

  // noswap_q remembers that the previous phase was quiet; two quiet phases in a row mean sorted.
  assign sort_done = (phase_q == PW'(N - 1)) ||
                     ((EARLY_EXIT != 0) && (phase_q != '0) && !any_swap && noswap_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      phase_q  <= '0;
      phases_q <= '0;
      noswap_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      phases_q <= phases_d;
      noswap_q <= noswap_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    phases_d = phases_q;
    noswap_d = noswap_q;
    buf_d    = buf_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
      S_LOAD: begin
        if (in_fire) begin
          buf_d[idx_q] = bus.in_data;
          if (idx_at_end) begin
            state_d  = S_SORT;
            idx_d    = '0;
            phase_d  = '0;
            phases_d = '0;
            noswap_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SORT: begin
        buf_d    = cx;
        phase_d  = phase_q + 1'b1;
        phases_d = phases_q + 1'b1;
        noswap_d = !any_swap;
        if (sort_done) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (idx_at_end) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    bus.out_last    = 1'b0;
    bus.busy        = 1'b0;
    bus.sort_phases = phases_q;
    case (state_q)
      S_LOAD: begin
        bus.in_ready = 1'b1;
      end
      S_SORT: begin
        bus.busy = 1'b1;
      end
      S_DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = buf_q[idx_q];
        bus.out_last  = idx_at_end;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed batches with hand-sorted expectations queued by the driver and checked by output monitors.
module tb_sort_seq_ctrl;

  typedef logic [7:0] vec6_t [6];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sort_seq_ctrl_if #(.N(6), .W(8)) if0 ();
  sort_seq_ctrl_if #(.N(6), .W(8)) if1 ();

  sort_seq_ctrl #(.N(6), .W(8), .EARLY_EXIT(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  sort_seq_ctrl #(.N(6), .W(8), .EARLY_EXIT(0)) u_dut_ne (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   exp_k = -1;
  int   t_last = 0;
  int   t1_last = 0;
  int   n_sent = 0;
  int   n_acc = 0;
  bit   bp = 1'b0;
  bit   seen0 = 1'b0;
  bit   seen1 = 1'b0;
  bit   p_hold = 1'b0;
  bit   p_xn = 1'b0;
  bit   p_xl = 1'b0;
  logic [7:0] p_d;
  logic       p_l;
  exp_t e0, e1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if0.out_ready = (bp && if0.out_ready === 1'b1) ? 1'b0 : 1'b1;
  assign if1.out_ready = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor for the early-exit instance; samples settled values between edges.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      p_hold = 1'b0;
      p_xn   = 1'b0;
      p_xl   = 1'b0;
      seen0  = 1'b0;
    end else begin
      if (if0.in_valid && if0.in_ready) n_acc++;
      if (p_hold) begin
        chk("hold_valid", int'(if0.out_valid), 1);
        chk("hold_data", int'(if0.out_data), int'(p_d));
        chk("hold_last", int'(if0.out_last), int'(p_l));
      end
      if (p_xn) chk("drain_gap", int'(if0.out_valid), 1);
      if (p_xl) begin
        chk("post_drain_in_ready", int'(if0.in_ready), 1);
        chk("post_drain_out_valid", int'(if0.out_valid), 0);
      end
      if (if0.out_valid) begin
        chk("in_ready_in_drain", int'(if0.in_ready), 0);
        if (!seen0) begin
          seen0 = 1'b1;
          if (exp_k >= 0) begin
            chk("latency", cyc - t_last, exp_k);
            chk("sort_phases", int'(if0.sort_phases), exp_k);
          end
        end
      end
      p_hold = if0.out_valid && !if0.out_ready;
      p_d    = if0.out_data;
      p_l    = if0.out_last;
      p_xn   = 1'b0;
      p_xl   = 1'b0;
      if (if0.out_valid && if0.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0d, expected no word", if0.out_data);
        end else begin
          e0 = exp_q.pop_front();
          chk("out_data", int'(if0.out_data), int'(e0.d));
          chk("out_last", int'(if0.out_last), int'(e0.l));
        end
        if (if0.out_last) begin
          p_xl  = 1'b1;
          seen0 = 1'b0;
        end else begin
          p_xn = 1'b1;
        end
      end
    end
  end

  // Monitor for the always-full-phases instance.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      seen1 = 1'b0;
    end else begin
      if (if1.out_valid && !seen1) begin
        seen1 = 1'b1;
        chk("ne_latency", cyc - t1_last, 6);
        chk("ne_sort_phases", int'(if1.sort_phases), 6);
      end
      if (if1.out_valid && if1.out_ready) begin
        if (exp1_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ne_unexpected_output: got %0d, expected no word", if1.out_data);
        end else begin
          e1 = exp1_q.pop_front();
          chk("ne_out_data", int'(if1.out_data), int'(e1.d));
          chk("ne_out_last", int'(if1.out_last), int'(e1.l));
        end
        if (if1.out_last) seen1 = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input int gap);
    int w;
    repeat (gap) begin
      if0.in_valid = 1'b0;
      @(negedge clk);
    end
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    w = 0;
    while (!if0.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) timeout("in_ready_wait");
    @(negedge clk);
    n_sent++;
    t_last = cyc;
  endtask

  task automatic send_batch(input vec6_t v, input int gap, input bit hold);
    for (int i = 0; i < 6; i++) send_word(v[i], (i % 2 == 1) ? gap : 0);
    if0.in_valid = hold;
    if0.in_data  = 8'hEE;
  endtask

  task automatic expect_batch(input vec6_t s, input int k);
    exp_t e;
    exp_k = k;
    for (int i = 0; i < 6; i++) begin
      e.d = s[i];
      e.l = (i == 5);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drained();
    int w;
    w = 0;
    while (!(exp_q.size() == 0 && if0.in_ready) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) timeout("drain_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   w;
    vec6_t v1, s1;
    reset        = 1'b0;
    if0.in_valid = 1'b0;
    if0.in_data  = 8'h00;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(if0.in_ready), 0);
    chk("rst_out_valid", int'(if0.out_valid), 0);
    chk("rst_out_last", int'(if0.out_last), 0);
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_sort_phases", int'(if0.sort_phases), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("load_after_idle", int'(if0.in_ready), 1);
    chk("load_not_busy", int'(if0.busy), 0);

    // Reverse order needs every phase.
    expect_batch('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 6);
    send_batch('{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
    wait_drained();

    // Already sorted: two quiet phases end the sort.
    expect_batch('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 2);
    send_batch('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 0, 1'b0);
    wait_drained();
    chk("phases_held_in_load", int'(if0.sort_phases), 2);

    // Duplicates and extremes under alternating backpressure.
    bp = 1'b1;
    expect_batch('{8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd255}, -1);
    send_batch('{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0}, 0, 1'b0);
    wait_drained();
    bp = 1'b0;

    // Reset during phase 3 discards the batch.
    exp_k = -1;
    send_batch('{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
    w = 0;
    while (cyc < t_last + 3 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mid_sort_busy", int'(if0.busy), 1);
    chk("mid_sort_phases", int'(if0.sort_phases), 3);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(if0.out_valid), 0);
    chk("mid_rst_busy", int'(if0.busy), 0);
    chk("mid_rst_sort_phases", int'(if0.sort_phases), 0);
    chk("mid_rst_in_ready", int'(if0.in_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_load", int'(if0.in_ready), 1);
    expect_batch('{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 6);
    send_batch('{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4}, 0, 1'b0);
    wait_drained();

    // Gapped loads with in_valid held high through SORT/DRAIN, back to back.
    expect_batch('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 5);
    send_batch('{8'd3, 8'd1, 8'd2, 8'd6, 8'd4, 8'd5}, 2, 1'b1);
    wait_drained();
    expect_batch('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, 2);
    send_batch('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, 1, 1'b1);
    wait_drained();
    if0.in_valid = 1'b0;
    chk("accepted_words", n_acc, n_sent);

    // Early exit disabled: sorted input still takes all phases.
    v1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    s1 = v1;
    for (int i = 0; i < 6; i++) begin
      e.d = s1[i];
      e.l = (i == 5);
      exp1_q.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = v1[i];
      w = 0;
      while (!if1.in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) timeout("ne_in_ready_wait");
      @(negedge clk);
      t1_last = cyc;
    end
    if1.in_valid = 1'b0;
    w = 0;
    while (exp1_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) timeout("ne_drain_wait");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
Name: sort_seq_ctrl

Overview:
Self-contained sequencing controller for the 6-entry byte sorter.
- Collects N words from a valid/ready input stream into an internal buffer.
- Schedules odd-even transposition compare-exchange phases, one phase per cycle, with optional early termination.
- Streams the ascending result out over a valid/ready interface.
- Sits between the upstream data source and downstream consumer; one batch in flight at a time.

Parameters:
N, 6, number of elements per batch (even, >=2)
W, 8, element width in bits
EARLY_EXIT, 1, 1 = stop sorting after two consecutive phases with no swap; 0 = always run N phases

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  block accepts a word (LOAD state only)
in_data  in  W  upstream word, unsigned
out_valid  out  1  sorted word valid
out_ready  in  1  downstream accepts word
out_data  out  W  sorted word, ascending order
out_last  out  1  high with the N-th (largest) output word
busy  out  1  high in SORT or DRAIN
sort_phases  out  clog2(N+1)  phases executed for the current or last batch

Behaviour:
- Interface: one clock; reset is synchronous and active-low. It is sampled on the clk rising edge only.
- Reset values, while reset=0: state=IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, sort_phases=0, load/drain index=0. Buffer contents are don't-care.
- States: IDLE -> LOAD -> SORT -> DRAIN -> LOAD.
- IDLE: lasts exactly one cycle after reset release, then LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready stores in_data at buf[idx] and increments idx.
  - On the N-th accept, go to SORT with idx=0, phase=0, sort_phases=0.
- SORT:
  - in_ready=0; in_valid is ignored.
  - Phase p executes in the p-th SORT cycle.
  - Even p compares pairs (0,1),(2,3),...,(N-2,N-1). Odd p compares pairs (1,2),...,(N-3,N-2).
  - Per pair: swap if buf[i] > buf[i+1] (unsigned). Equal values do not swap.
  - sort_phases increments each SORT cycle.
  - Exit to DRAIN after phase N-1.
  - If EARLY_EXIT=1, also exit after any phase p>=1 where phase p and phase p-1 both produced no swap.
- DRAIN:
  - out_valid=1 and out_data=buf[idx].
  - out_last=1 when idx=N-1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: idx++. After the transfer with idx=N-1, go to LOAD next cycle with idx=0 and out_valid=0.
- Latency: let the last input accept be at edge t.
  - Phases occupy cycles t+1 .. t+k.
  - out_valid rises at cycle t+k+1, where k=sort_phases (N, or fewer with early exit, minimum 2).
- No overlap: no input is accepted during SORT or DRAIN.
- sort_phases holds its final value through DRAIN and LOAD until the next SORT entry clears it.
- busy=1 exactly in SORT and DRAIN.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all outputs at reset values.
  - The partial batch is discarded.
  - No out_valid until a fresh full batch is loaded.
- in_valid=1 held across the LOAD->SORT boundary: only N words are accepted. The extra word waits with in_ready=0.

Test Plan:
- Reverse input 6,5,4,3,2,1 (EARLY_EXIT=1, out_ready=1): output 1,2,3,4,5,6 in consecutive cycles, out_last with 6, sort_phases=6, out_valid at t+7.
- Sorted input 1,2,3,4,5,6, EARLY_EXIT=1: sort_phases=2, out_valid at t+3, output unchanged. Same input with EARLY_EXIT=0: sort_phases=6, out_valid at t+7.
- Duplicates/extremes 5,5,0,255,5,0: output 0,0,5,5,5,255, out_last only on 255.
- Backpressure: out_ready alternates 0/1 during DRAIN. Each word is held while out_ready=0, no word is skipped or repeated, and in_ready=0 until the cycle after the 6th transfer.
- Reset mid-operation:
  - Drive reset=0 for one cycle during SORT phase 3: next cycle IDLE, out_valid=0, busy=0, sort_phases=0, then LOAD with in_ready=1.
  - A new batch 9,8,7,6,5,4 yields 4..9.
- Gapped input: in_valid=1 with gaps during LOAD, and in_valid=1 asserted continuously during SORT/DRAIN. Exactly 6 words are accepted per batch, and back-to-back batches 3,1,2,6,4,5 then 0,0,0,0,0,1 both sort correctly.
